bf16_div: RTL and testbench
===========================

// Module: bf16_div
// PURPOSE
//  Iterative bfloat16 divider (out = a / b); the inverse-operation companion to the BF16 multiplier in the MAC datapath.
//  Restoring radix-2 mantissa division, one quotient bit per cycle, with a start/ready/valid handshake.
//  Special-value policy matches the MAC unit:
//   - no Inf/NaN is ever produced;
//   - denormal inputs are flushed to zero;
//   - the default rounding mode is truncation.
// PARAMETERS
//  BIAS  8'd127  exponent bias
// PORTS
//  clk    in   1   clock, rising edge
//  rst    in   1   reset, asynchronous, active-high
//  start  in   1   request; accepted only when ready=1
//  a      in   16  dividend, bf16 {sign, exp[7:0], man[6:0]}; sampled at accept
//  b      in   16  divisor, bf16; sampled at accept
//  ready  out  1   high in IDLE
//  valid  out  1   one-cycle pulse; out is new in that cycle
//  out    out  16  quotient, bf16; holds value until the next valid
// BEHAVIOUR
//  Reset: state=IDLE, ready=1, valid=0, out=16'h0000, iteration counter=0. Reset mid-operation aborts with no valid.
//  FSM: IDLE -> DIV -> NORM -> IDLE.
//   - IDLE & start: latch sign=a[15]^b[15], both exponents and both 8-bit mantissas {1, man}.
//   - Normal operands: go to DIV with cnt=QB-1 and rem={1'b0, man_a}.
//   - Special operands: skip DIV and go straight to NORM.
//  DIV: one restoring step per cycle.
//   - if rem >= man_b: qbit=1, rem = rem - man_b; else qbit=0.
//   - then rem = rem << 1; quotient shifts qbit in at the LSB.
//   - leave for NORM when cnt==0.
//  NORM: register out, pulse valid, return to IDLE.
//  QB = 9 quotient bits (10 with the macro). q[QB-1] is the integer bit; the quotient lies in (0.5, 2).
//  Exponent, 10-bit signed:
//   - q[QB-1]=1: mant = q[QB-2:QB-8], e = ea - eb + BIAS.
//   - q[QB-1]=0: mant = q[QB-3:QB-9], e = ea - eb + BIAS - 1.
//   - e <= 0 -> out = 16'h0000.
//   - e >= 255 -> out = {sign, 8'hFE, 7'h7F}.
//  Special cases, in priority order:
//   1. a or b NaN -> 16'h0000
//   2. b is zero (or denormal) -> {sign, FE, 7F}
//   3. a Inf -> {sign, FE, 7F}
//   4. b Inf -> 16'h0000
//   5. a is zero (or denormal) -> 16'h0000
//  Latency, counted from the start-accept edge to the edge that asserts valid:
//   - normal operands: QB+1 edges (10 by default);
//   - special operands: 1 edge.
//  Handshake:
//   - start while ready=0 is ignored and never queued;
//   - ready rises on the same edge as valid, so a back-to-back start in the valid cycle is accepted.
// CONFIGURATION
//  BF16_DIV_RNE_EN
//   - defined: QB=10 and round-to-nearest-even. Guard = next quotient bit; sticky = (final rem != 0). A mantissa carry-out increments e before the overflow check. Normal-operand latency becomes 11.
//   - undefined: QB=9, truncation, latency 10.
// STRUCTURE
//  Shared package bf16_pkg (also used by the multiplier): field widths, BIAS, MAXF_MAG = 15'h7F7F, state enum, classify helpers (is_zero, is_inf, is_nan).
//  One natural sub-module, bf16_div_step: combinational compare/subtract/shift for a single restoring step.
// TESTING
//  1. 0x3F80 / 0x4000 (1.0 / 2.0) -> out 0x3F00; valid exactly 10 cycles after accept; ready low throughout.
//  2. 0x4040 / 0x4000 (3.0 / 2.0) -> 0x3FC0. Then 0x3F80 / 0x4040 -> 0x3EAA truncated, or 0x3EAB with BF16_DIV_RNE_EN.
//  3. Specials, each valid 1 cycle after accept:
//     - 0x3F80 / 0x0000 -> 0x7F7F
//     - 0xBF80 / 0x0000 -> 0xFF7F
//     - 0x7FC0 / 0x3F80 -> 0x0000
//     - 0x3F80 / 0x7F80 -> 0x0000
//  4. Range limits:
//     - 0x7F00 / 0x0080 -> 0x7F7F (overflow clamp)
//     - 0x0080 / 0x7F00 -> 0x0000 (underflow)
//     - 0xC000 / 0x4000 -> 0xBF80
//  5. start pulsed mid-DIV with different operands: ignored, first result unchanged. A start in the valid cycle is accepted back-to-back.
//  6. rst asserted mid-DIV: outputs go to reset values immediately; no valid follows; the next start completes normally.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared bfloat16 definitions for the MAC datapath (multiplier and divider):
// field widths, exponent bias, saturation magnitude, divider state encoding
// and operand classification helpers.
// Optional feature: define BF16_DIV_RNE_EN for a 10-bit divider quotient
// with round-to-nearest-even; otherwise 9 bits with truncation.
package bf16_pkg;

    localparam int          EXP_W    = 8;
    localparam int          MAN_W    = 7;
    localparam logic [7:0]  BIAS     = 8'd127;
    localparam logic [14:0] MAXF_MAG = 15'h7F7F;

`ifdef BF16_DIV_RNE_EN
    localparam int QB = 10;
`else
    localparam int QB = 9;
`endif
    localparam int CNT_W = $clog2(QB);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_NORM
    } div_state_e;

    // Zero exponent covers both true zero and denormals, which are flushed.
    function automatic logic is_zero(input logic [15:0] x);
        return x[14:7] == 8'h00;
    endfunction

    function automatic logic is_inf(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] == 7'h00);
    endfunction

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] != 7'h00);
    endfunction

endpackage

// File: rtl/bf16_div_if.sv
// Request/response bundle for the bf16 divider: start/ready accept a
// request, valid marks a new quotient on out.
interface bf16_div_if;

    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        valid;
    logic [15:0] out;

    modport master (output start, a, b, input ready, valid, out);
    modport slave  (input start, a, b, output ready, valid, out);

endinterface

// File: rtl/bf16_div_step.sv
// One restoring radix-2 division step: compare, conditionally subtract,
// then shift the partial remainder left by one.
module bf16_div_step
    import bf16_pkg::*;
(
    input  logic [MAN_W+1:0] rem,
    input  logic [MAN_W:0]   divisor,
    output logic             qbit,
    output logic [MAN_W+1:0] rem_next
);

    logic [MAN_W+1:0] diff;

    // Remainder stays below twice the divisor, so 9 bits hold it after the shift.
    always_comb begin
        // NOTE: always_comb assigns every output on every path, so no latch is inferred.
        qbit     = (rem >= {1'b0, divisor});
        diff     = qbit ? (rem - {1'b0, divisor}) : rem;
        rem_next = diff << 1;
    end

endmodule

// File: rtl/bf16_div.sv
// Iterative bfloat16 divider, out = a / b, one quotient bit per cycle.
// No Inf/NaN is produced, denormals are flushed to zero, results saturate
// to +/-MAXF. Define BF16_DIV_RNE_EN for round-to-nearest-even (10 quotient
// bits, one extra cycle); the default build truncates.
module bf16_div
    import bf16_pkg::*;
(
    input logic       clk,
    input logic       rst,
    bf16_div_if.slave bus
);

    div_state_e       state_q, state_d;
    logic             ready_c;
    logic [CNT_W-1:0] cnt_q;
    logic [MAN_W+1:0] rem_q;
    logic [MAN_W:0]   mb_q;
    logic [QB-1:0]    quo_q;
    logic             sign_q;
    logic [EXP_W-1:0] ea_q, eb_q;
    logic             spec_q;
    logic [15:0]      spec_out_q;
    logic [15:0]      out_q;
    logic             valid_q;

    logic             sign_in, sp_hit;
    logic [15:0]      sp_out;
    logic             step_qbit;
    logic [MAN_W+1:0] step_rem;

    logic signed [9:0] e_base, e_adj;
    logic [MAN_W-1:0]  mant;
    logic [15:0]       norm_out;
`ifdef BF16_DIV_RNE_EN
    logic              guard, sticky;
    logic [MAN_W:0]    mant_rnd;
`endif

    bf16_div_step u_step (
        .rem      (rem_q),
        .divisor  (mb_q),
        .qbit     (step_qbit),
        .rem_next (step_rem)
    );

    // Classify the incoming operands; specials bypass the iteration entirely.
    always_comb begin
        sign_in = bus.a[15] ^ bus.b[15];
        sp_hit  = 1'b1;
        sp_out  = 16'h0000;
        if (is_nan(bus.a) || is_nan(bus.b)) sp_out = 16'h0000;
        else if (is_zero(bus.b))            sp_out = {sign_in, MAXF_MAG};
        else if (is_inf(bus.a))             sp_out = {sign_in, MAXF_MAG};
        else if (is_inf(bus.b))             sp_out = 16'h0000;
        else if (is_zero(bus.a))            sp_out = 16'h0000;
        else                                sp_hit = 1'b0;
    end

    // Normalise the quotient, adjust the exponent and clamp to the bf16 range.
    always_comb begin
        e_base = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + $signed({2'b00, BIAS});
        if (quo_q[QB-1]) begin
            mant  = quo_q[QB-2:QB-8];
            e_adj = e_base;
        end else begin
            mant  = quo_q[QB-3:QB-9];
            e_adj = e_base - 10'sd1;
        end
`ifdef BF16_DIV_RNE_EN
        // With the integer bit set, quo_q[0] lies below the guard and joins the sticky.
        guard    = quo_q[QB-1] ? quo_q[1] : quo_q[0];
        sticky   = (|rem_q) | (quo_q[QB-1] & quo_q[0]);
        mant_rnd = {1'b0, mant} + {{MAN_W{1'b0}}, guard & (sticky | mant[0])};
        if (mant_rnd[MAN_W]) e_adj = e_adj + 10'sd1;
        mant = mant_rnd[MAN_W-1:0];
`endif
        if (e_adj <= 10'sd0)        norm_out = 16'h0000;
        else if (e_adj >= 10'sd255) norm_out = {sign_q, MAXF_MAG};
        else                        norm_out = {sign_q, e_adj[7:0], mant};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (bus.start) state_d = sp_hit ? ST_NORM : ST_DIV;
            end
            ST_DIV:  if (cnt_q == '0) state_d = ST_NORM;
            ST_NORM: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, restoring iteration and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            mb_q       <= '0;
            quo_q      <= '0;
            sign_q     <= 1'b0;
            ea_q       <= '0;
            eb_q       <= '0;
            spec_q     <= 1'b0;
            spec_out_q <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (bus.start) begin
                    sign_q     <= sign_in;
                    ea_q       <= bus.a[14:7];
                    eb_q       <= bus.b[14:7];
                    mb_q       <= {1'b1, bus.b[6:0]};
                    rem_q      <= {2'b01, bus.a[6:0]};
                    quo_q      <= '0;
                    cnt_q      <= CNT_W'(QB - 1);
                    spec_q     <= sp_hit;
                    spec_out_q <= sp_out;
                end
                ST_DIV: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[QB-2:0], step_qbit};
                    if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
                end
                ST_NORM: begin
                    out_q   <= spec_q ? spec_out_q : norm_out;
                    valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = ready_c;
    assign bus.valid = valid_q;
    assign bus.out   = out_q;

endmodule

// File: tb/tb_bf16_div.sv
// Self-checking bench for bf16_div: directed vector table, hand-written
// handshake/reset sequences and randomized operands checked against an
// integer-arithmetic reference of the bf16 division rules.
module tb_bf16_div;

`ifdef BF16_DIV_RNE_EN
    localparam int          TB_QB     = 10;
    localparam logic [15:0] ONE_THIRD = 16'h3EAB;
`else
    localparam int          TB_QB     = 9;
    localparam logic [15:0] ONE_THIRD = 16'h3EAA;
`endif
    localparam int NORM_LAT = TB_QB + 1;
    localparam int SPEC_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    bf16_div_if bus ();

    bf16_div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_out;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference: exact integer quotient of the significands, then the bf16 rules.
    // Returns {special, result}.
    function automatic logic [16:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        int  ea, eb, ma, mb, e, num, t;
        bit  s;
`ifdef BF16_DIV_RNE_EN
        bit  guard, sticky;
`endif
        s  = a[15] ^ b[15];
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        if ((ea == 255 && a[6:0] != 0) || (eb == 255 && b[6:0] != 0)) return {1'b1, 16'h0000};
        if (eb == 0)   return {1'b1, s, 15'h7F7F};
        if (ea == 255) return {1'b1, s, 15'h7F7F};
        if (eb == 255) return {1'b1, 16'h0000};
        if (ea == 0)   return {1'b1, 16'h0000};
        ma = 128 + int'(a[6:0]);
        mb = 128 + int'(b[6:0]);
        e  = ea - eb + 127;
        if (ma >= mb) num = ma << 7;
        else begin
            num = ma << 8;
            e   = e - 1;
        end
        t = num / mb;
`ifdef BF16_DIV_RNE_EN
        guard  = (((num * 2) / mb) % 2) == 1;
        sticky = ((num * 2) % mb) != 0;
        if (guard && (sticky || (t % 2 == 1))) t = t + 1;
        if (t == 256) begin
            t = 128;
            e = e + 1;
        end
`endif
        if (e <= 0)   return {1'b0, 16'h0000};
        if (e >= 255) return {1'b0, s, 15'h7F7F};
        return {1'b0, s, e[7:0], t[6:0]};
    endfunction

    // Issue one request at a negedge with ready=1, wait for valid and check it.
    // inject_at >= 0 pulses start with other operands while the divider is busy.
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_out, input int exp_lat, input int inject_at);
        int lat;
        bit got;
        bit rdy_low;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        lat     = 0;
        got     = 1'b0;
        rdy_low = 1'b1;
        while (!got && lat <= 40) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.valid) got = 1'b1;
            else begin
                if (bus.ready) rdy_low = 1'b0;
                if (lat == inject_at) begin
                    bus.a     = 16'h4100;
                    bus.b     = 16'h3F80;
                    bus.start = 1'b1;
                end
                lat++;
            end
        end
        check({name, " valid seen"}, 32'(got), 32'd1);
        if (got) begin
            check({name, " latency"}, lat, exp_lat);
            check({name, " out"}, 32'(bus.out), 32'(exp_out));
            check({name, " ready at valid"}, 32'(bus.ready), 32'd1);
            check({name, " ready low while busy"}, 32'(rdy_low), 32'd1);
        end
    endtask

    function automatic logic [15:0] rand_operand();
        logic [7:0] e;
        logic [6:0] m;
        int         cat;
        cat = int'($urandom_range(0, 15));
        m   = 7'($urandom);
        case (cat)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'hFE;
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, m};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] r;
        logic [15:0] ra, rb;
        bit          spurious;

        vecs.push_back('{16'h3F80, 16'h4000, 16'h3F00, NORM_LAT, "1.0/2.0"});
        vecs.push_back('{16'h4040, 16'h4000, 16'h3FC0, NORM_LAT, "3.0/2.0"});
        vecs.push_back('{16'h3F80, 16'h4040, ONE_THIRD, NORM_LAT, "1.0/3.0"});
        vecs.push_back('{16'h3F80, 16'h0000, 16'h7F7F, SPEC_LAT, "1/+0"});
        vecs.push_back('{16'hBF80, 16'h0000, 16'hFF7F, SPEC_LAT, "-1/+0"});
        vecs.push_back('{16'h7FC0, 16'h3F80, 16'h0000, SPEC_LAT, "NaN/1"});
        vecs.push_back('{16'h3F80, 16'h7F80, 16'h0000, SPEC_LAT, "1/Inf"});
        vecs.push_back('{16'h7F00, 16'h0080, 16'h7F7F, NORM_LAT, "overflow"});
        vecs.push_back('{16'h0080, 16'h7F00, 16'h0000, NORM_LAT, "underflow"});
        vecs.push_back('{16'hC000, 16'h4000, 16'hBF80, NORM_LAT, "-2/2"});
        vecs.push_back('{16'h0000, 16'h3F80, 16'h0000, SPEC_LAT, "0/1"});
        vecs.push_back('{16'h7F80, 16'h3F80, 16'h7F7F, SPEC_LAT, "Inf/1"});
        vecs.push_back('{16'h0001, 16'h3F80, 16'h0000, SPEC_LAT, "denorm/1"});
        vecs.push_back('{16'hBF80, 16'h8001, 16'h7F7F, SPEC_LAT, "-1/-denorm"});
        vecs.push_back('{16'h7F80, 16'h0000, 16'h7F7F, SPEC_LAT, "Inf/0"});

        bus.start = 1'b0;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        #1;
        check("reset ready", 32'(bus.ready), 32'd1);
        check("reset valid", 32'(bus.valid), 32'd0);
        check("reset out", 32'(bus.out), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table, each request issued in the valid cycle of the previous one.
        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].lat, -1);

        // Result holds and valid stays low while idle.
        @(negedge clk);
        @(negedge clk);
        check("idle valid low", 32'(bus.valid), 32'd0);
        check("idle out held", 32'(bus.out), 32'(vecs[vecs.size()-1].exp_out));

        // A start while busy is ignored; the result belongs to the first request.
        run_op("start mid-DIV", 16'h3F80, 16'h4000, 16'h3F00, NORM_LAT, 3);
        @(negedge clk);
        @(negedge clk);
        check("no queued request", 32'(bus.valid), 32'd0);
        check("ready after ignored start", 32'(bus.ready), 32'd1);

        // Reset mid-DIV aborts the request without a valid.
        bus.a     = 16'h4040;
        bus.b     = 16'h4000;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid reset ready", 32'(bus.ready), 32'd1);
        check("mid reset valid", 32'(bus.valid), 32'd0);
        check("mid reset out", 32'(bus.out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        spurious = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.valid) spurious = 1'b1;
        end
        check("no valid after reset", 32'(spurious), 32'd0);
        run_op("after reset", 16'h3F80, 16'h4040, ONE_THIRD, NORM_LAT, -1);

        // Randomized operands against the reference.
        for (int i = 0; i < 300; i++) begin
            ra = rand_operand();
            rb = rand_operand();
            r  = ref_div(ra, rb);
            run_op($sformatf("rand %0d %h/%h", i, ra, rb), ra, rb, r[15:0],
                   r[16] ? SPEC_LAT : NORM_LAT, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
